// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with load and wrap pulse, driving a scanned 7-segment display.
// Count/wrap update on the next edge; seg/an are registered, so the display lags bcd by one cycle.
module bcd_counter_display #(
  parameter int NUM_DIGITS = 4,
  parameter int STEP       = 2,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    cathod,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [4*NUM_DIGITS-1:0] cnt_next;
  logic [4*NUM_DIGITS-1:0] load_clamped;
  logic                    wrap_q;
  logic                    carry_out;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           dig_idx;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // Decimal ripple: carry on the way up, ten's-complement borrow on the way down.
  always_comb begin
    int d;
    int t;
    int c;
    cnt_next = bcd_q;
    c = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = int'(bcd_q[4*i +: 4]);
      t = (i == 0) ? STEP : 0;
      if (up) begin
        t = d + t + c;
        if (t > 9) begin
          t = t - 10;
          c = 1;
        end else begin
          c = 0;
        end
      end else begin
        t = d - t - c;
        if (t < 0) begin
          t = t + 10;
          c = 1;
        end else begin
          c = 0;
        end
      end
      cnt_next[4*i +: 4] = t[3:0];
    end
    carry_out = (c != 0);
  end

  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else if (load) begin
      bcd_q  <= load_clamped;
      wrap_q <= 1'b0;
    end else if (en) begin
      bcd_q  <= cnt_next;
      wrap_q <= carry_out;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == IW'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = all_zero && (k != 0) && (BLANK_LZ != 0);
    end
  end

  always_comb begin
    cur_digit = bcd_q[4*dig_idx +: 4];
    seg_next  = blank[dig_idx] ? 7'b0000000 : decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_next;
      an_q  <= NUM_DIGITS'(1) << dig_idx;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;
  assign seg  = cathod ? seg_q : ~seg_q;
  assign an   = cathod ? an_q  : ~an_q;
  assign dp   = ~cathod;

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
Parametrised successor to the fixed 3-digit even counter. The block holds an N-digit BCD up/down counter with a configurable step, synchronous load and a wrap flag. It also drives a time-multiplexed 7-segment display with a runtime common-anode/common-cathode polarity select and optional leading-zero blanking. It sits at board top level between the control logic and the display pins.

Parameters:
- NUM_DIGITS, 4, number of BCD digits counted and displayed (2..8).
- STEP, 2, decimal increment/decrement per enabled cycle (1..9).
- SCAN_DIV, 100000, clock cycles each digit stays selected (>=2).
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load of load_val.
- load_val  in  4*NUM_DIGITS  BCD value to load; digit 0 is in bits [3:0].
- cathod  in  1  0 = common-anode (active-low seg/an); 1 = common-cathode (active-high).
- bcd  out  4*NUM_DIGITS  current count, BCD, digit 0 in LSBs.
- wrap  out  1  one-cycle pulse when the count wraps past 0 / 10^N-1.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per cathod.
- an  out  NUM_DIGITS  digit selects, one-hot active, polarity per cathod.
- dp  out  1  decimal point, always driven inactive.

Behaviour:
- Reset (rst=1 at a clock edge):
  - bcd=0, wrap=0, scan counter=0, digit index=0.
  - Internal seg/an registers go to "off", so an is all inactive and seg is all off after the polarity mapping.
  - Reset overrides load and en, including mid-scan and mid-count.
- Priority at each edge: rst > load > en > hold.
- Load:
  - bcd <= load_val on the next edge; wrap=0.
  - Any load nibble >9 is clamped to 9.
- Count (en=1, load=0):
  - Up: bcd <= (bcd + STEP) mod 10^N, using per-digit BCD add with decimal carry ripple.
  - Down: bcd <= (bcd - STEP) mod 10^N, using ten's-complement borrow.
  - wrap=1 for exactly the cycle following an edge where a carry/borrow leaves the top digit. Otherwise wrap=0.
  - Examples (N=4, STEP=2): 9998 up -> 0000 with wrap; 0000 down -> 9998 with wrap; 0001 down -> 9999 with wrap.
  - up changes take effect on the same edge, with no extra latency.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously, independent of en.
  - On the terminal count it resets to 0 and the digit index advances 0,1,..,N-1,0.
- Display pipeline:
  - seg/an registers update every cycle from the current digit index and current bcd, giving 1-cycle latency.
  - A bcd change becomes visible on the selected digit one cycle later.
- Decoder, active-high form (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k is blanked (seg all off, an still asserted) when digit k and every digit above it are 0.
  - Digit 0 is never blanked.
- Polarity: applied combinationally after the registers.
  - cathod=0: seg and an are inverted.
  - cathod=1: seg and an are passed through.
  - A cathod change is reflected in the same cycle.
- dp is always inactive: 1 when cathod=0, 0 when cathod=1.

Test Plan (NUM_DIGITS=4, STEP=2, SCAN_DIV=4, BLANK_LZ=1):
- Reset: rst=1 for 3 cycles with cathod=0, en=1 -> bcd=16'h0000, wrap=0, an=4'b1111, seg=7'h7F, dp=1. Release rst -> scan starts at digit 0.
- Up count with carry: from 0, en=1, up=1 for 5 cycles -> bcd=16'h0010. Then 45 more cycles -> bcd=16'h0100. wrap stays 0.
- Wrap both ways:
  - Load 16'h9998, en up 1 cycle -> bcd=16'h0000, wrap=1 for exactly one cycle.
  - Then en down 1 cycle -> bcd=16'h9998, wrap=1 for one cycle.
- Load priority and clamp:
  - load=1 with en=1 and load_val=16'h1234 -> bcd=16'h1234.
  - load_val=16'hA0F5 -> bcd=16'h9095.
  - rst=1 together with load -> bcd=0.
- Scan and blanking: bcd=16'h0007, cathod=0.
  - an steps 1110,1101,1011,0111, 4 cycles each, then repeats.
  - seg=7'b1111000 while digit 0 is selected, 7'b1111111 on the other digits.
- Polarity: same state with cathod=1.
  - Digit 0: an=4'b0001, seg=7'b0000111, dp=0.
  - bcd=16'h0800 shows the digit 1 and digit 0 zeros as 0111111, and blanks digit 3.
